// File: rtl/stack_pkg.sv
// Shared definitions for the stack block: opcode width and opcode encoding.
// Codes 3'b001..3'b011 have no enum member and decode as no-operation.
package stack_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_NOP  = 3'b000,
      OP_ADD  = 3'b100,
      OP_MUL  = 3'b101,
      OP_PUSH = 3'b110,
      OP_POP  = 3'b111
   } opcode_t;

endpackage

// File: rtl/stack_if.sv
// Command/result bundle of the stack.
// There is no valid/ready handshake: the opcode is sampled and executed on
// every rising clock edge (OP_NOP is the idle command), and output_data and
// overflow are registered results that hold until the next operation that
// updates them. empty and full always reflect the current entry count.
interface stack_if
   import stack_pkg::*;
#(
   parameter int WIDTH = 8
) ();

   logic [OP_W-1:0]  opcode;
   logic [WIDTH-1:0] input_data;
   logic [WIDTH-1:0] output_data;
   logic             empty;
   logic             full;
   logic             overflow;

   // Command issuer: drives opcode/operand, observes results and status.
   modport master (
      output opcode,
      output input_data,
      input  output_data,
      input  empty,
      input  full,
      input  overflow
   );

   // The stack itself.
   modport slave (
      input  opcode,
      input  input_data,
      output output_data,
      output empty,
      output full,
      output overflow
   );

endinterface

// File: rtl/stack_alu.sv
// Combinational arithmetic for the stack: wrapped signed ADD and, when the
// STACK_MUL_EN macro is defined, wrapped signed MUL. Each operation also
// reports whether the true signed result fits in WIDTH bits.
module stack_alu
   import stack_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,      // second entry from the top
   input  logic [WIDTH-1:0] b,      // top entry
   input  opcode_t          op,
   output logic [WIDTH-1:0] result,
   output logic             ovf
);

   logic [WIDTH-1:0] sum;
   logic             add_ovf;

   assign sum     = a + b;
   // Same-sign operands whose sum changes sign have left the signed range.
   assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

`ifdef STACK_MUL_EN
   logic [2*WIDTH-1:0] prod;
   logic               mul_ovf;

   // Sign-extend both operands so the 2*WIDTH unsigned product equals the
   // two's-complement signed product.
   assign prod    = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
   // The product fits in WIDTH signed bits only if its top WIDTH+1 bits agree.
   assign mul_ovf = !((&prod[2*WIDTH-1:WIDTH-1]) || (~|prod[2*WIDTH-1:WIDTH-1]));
`endif

   // Select the result and overflow flag for the requested operation.
   always_comb begin
      result = '0;
      ovf    = 1'b0;
      case (op)
         OP_ADD: begin
            result = sum;
            ovf    = add_ovf;
         end
`ifdef STACK_MUL_EN
         OP_MUL: begin
            result = prod[WIDTH-1:0];
            ovf    = mul_ovf;
         end
`endif
         default: begin
            result = '0;
            ovf    = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/stack.sv
// LIFO stack with push/pop and in-place ADD (and MUL when STACK_MUL_EN is
// defined). One operation per clock; results are registered. The storage
// array is not reset; only the count and the result registers are.
module stack
   import stack_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int WIDTH = 8
) (
   input logic    clk,
   input logic    rst,
   stack_if.slave bus
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [CNT_W-1:0] count;

   logic [AW-1:0]    top_idx;
   logic [AW-1:0]    sec_idx;
   logic             two_plus;
   logic             do_push;
   logic             do_pop;
   logic             do_arith;
   logic [WIDTH-1:0] alu_result;
   logic             alu_ovf;

   assign bus.empty = (count == '0);
   assign bus.full  = (count == CNT_W'(DEPTH));

   // When count == DEPTH the low AW bits are zero, so the wrap to DEPTH-1
   // still addresses the top entry.
   assign top_idx  = count[AW-1:0] - AW'(1);
   assign sec_idx  = count[AW-1:0] - AW'(2);
   assign two_plus = (count >= CNT_W'(2));

   // Decode the executed operation; reset and ignored cases execute nothing.
   always_comb begin
      do_push  = 1'b0;
      do_pop   = 1'b0;
      do_arith = 1'b0;
      if (!rst) begin
         case (bus.opcode)
            OP_PUSH: do_push  = !bus.full;
            OP_POP:  do_pop   = !bus.empty;
            OP_ADD:  do_arith = two_plus;
`ifdef STACK_MUL_EN
            OP_MUL:  do_arith = two_plus;
`endif
            default: ;
         endcase
      end
   end

   stack_alu #(
      .WIDTH (WIDTH)
   ) u_alu (
      .a      (mem[sec_idx]),
      .b      (mem[top_idx]),
      .op     (opcode_t'(bus.opcode)),
      .result (alu_result),
      .ovf    (alu_ovf)
   );

   // Storage writes: push fills the next free slot, ADD/MUL replace the
   // second entry with the result (the old top is dropped by the count).
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[count[AW-1:0]] <= bus.input_data;
      end else if (do_arith) begin
         mem[sec_idx] <= alu_result;
      end
   end

   // Count, registered result and overflow flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         count           <= '0;
         bus.output_data <= '0;
         bus.overflow    <= 1'b0;
      end else if (do_push) begin
         count        <= count + CNT_W'(1);
         bus.overflow <= 1'b0;
      end else if (do_pop) begin
         count           <= count - CNT_W'(1);
         bus.output_data <= mem[top_idx];
         bus.overflow    <= 1'b0;
      end else if (do_arith) begin
         count           <= count - CNT_W'(1);
         bus.output_data <= alu_result;
         bus.overflow    <= alu_ovf;
      end
   end

endmodule

// File: tb/tb_stack.sv
// Directed bench for the stack (DEPTH=256, WIDTH=8). MUL expectations follow
// the STACK_MUL_EN build setting: with it, MUL computes; without, it holds.
module tb_stack;
   import stack_pkg::*;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   stack_if #(.WIDTH(8)) bus ();

   stack #(
      .DEPTH (256),
      .WIDTH (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value with its expected value
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one operation, let it execute, sample after the edge
   task automatic step(input logic [2:0] op, input logic [7:0] d);
      bus.opcode     = op;
      bus.input_data = d;
      @(posedge clk);
      #1;
   endtask

   // Drive reset together with an opcode that must be overridden
   task automatic reset_with(input logic [2:0] op);
      rst = 1'b1;
      step(op, 8'h55);
      rst = 1'b0;
   endtask

   task automatic check_out(input string tag, input logic [7:0] d, input logic o);
      check({tag, "_data"}, {24'd0, bus.output_data}, {24'd0, d});
      check({tag, "_ovf"}, {31'd0, bus.overflow}, {31'd0, o});
   endtask

   initial begin
      checks         = 0;
      errors         = 0;
      rst            = 1'b1;
      bus.opcode     = OP_PUSH;
      bus.input_data = 8'hAA;
      @(posedge clk);
      #1;
      reset_with(OP_PUSH);

      // Reset state
      check("rst_empty", {31'd0, bus.empty}, 32'd1);
      check("rst_full", {31'd0, bus.full}, 32'd0);
      check_out("rst", 8'h00, 1'b0);

      // Fill: full only after the 256th push
      for (int i = 1; i <= 256; i++) begin
         step(OP_PUSH, 8'(i));
         check("fill_full", {31'd0, bus.full}, (i == 256) ? 32'd1 : 32'd0);
         check("fill_empty", {31'd0, bus.empty}, 32'd0);
      end
      step(OP_PUSH, 8'h01);
      check("push_on_full", {31'd0, bus.full}, 32'd1);

      // Drain: 256 (wraps to 0), 255, ..., 1
      for (int i = 256; i >= 1; i--) begin
         step(OP_POP, 8'h00);
         check("drain_data", {24'd0, bus.output_data}, {24'd0, 8'(i)});
         check("drain_empty", {31'd0, bus.empty}, (i == 1) ? 32'd1 : 32'd0);
         check("drain_full", {31'd0, bus.full}, 32'd0);
      end
      step(OP_POP, 8'h00);
      check("pop_empty_hold", {24'd0, bus.output_data}, 32'h01);
      check("pop_empty_flag", {31'd0, bus.empty}, 32'd1);

      // 1 + -2 = -1, then -3 * 4 = -12
      step(OP_PUSH, 8'h01);
      step(OP_PUSH, 8'hFE);
      step(OP_ADD, 8'h00);
      check_out("add_small", 8'hFF, 1'b0);
      step(OP_PUSH, 8'hFD);
      step(OP_PUSH, 8'h04);
      step(OP_MUL, 8'h00);
`ifdef STACK_MUL_EN
      check_out("mul_small", 8'hF4, 1'b0);
`else
      check_out("mul_off_hold", 8'hFF, 1'b0);
`endif
      reset_with(OP_POP);
      check("rst2_empty", {31'd0, bus.empty}, 32'd1);

      // 127 + 1 overflows to -128; NOP holds it; push clears the flag
      step(OP_PUSH, 8'h7F);
      step(OP_PUSH, 8'h01);
      step(OP_ADD, 8'h00);
      check_out("add_ovf", 8'h80, 1'b1);
      step(OP_NOP, 8'h00);
      check_out("nop_hold", 8'h80, 1'b1);
      step(3'b010, 8'h00);
      check_out("code010_hold", 8'h80, 1'b1);
      step(OP_PUSH, 8'h81);
      check_out("push_clr_ovf", 8'h80, 1'b0);
      step(OP_PUSH, 8'hFE);
      step(OP_MUL, 8'h00);
`ifdef STACK_MUL_EN
      // -127 * -2 = 254: wraps to -2 and overflows; stack is [-128, -2]
      check_out("mul_ovf", 8'hFE, 1'b1);
      step(OP_ADD, 8'h00);
      check_out("add_neg_ovf", 8'h7E, 1'b1);
      step(OP_POP, 8'h00);
      check_out("pop_clr_ovf", 8'h7E, 1'b0);
      check("pop_last_empty", {31'd0, bus.empty}, 32'd1);
`else
      // MUL is a no-op; stack is [-128, -127, -2]
      check_out("mul_off_nop", 8'h80, 1'b0);
      step(OP_ADD, 8'h00);
      check_out("add_neg_ovf", 8'h7F, 1'b1);
      step(OP_POP, 8'h00);
      check_out("pop_clr_ovf", 8'h7F, 1'b0);
      check("pop_last_empty", {31'd0, bus.empty}, 32'd0);
`endif
      reset_with(OP_NOP);

      // Short-stack ADDs are ignored
      step(OP_ADD, 8'h00);
      check_out("add_empty", 8'h00, 1'b0);
      check("add_empty_flag", {31'd0, bus.empty}, 32'd1);
      step(OP_PUSH, 8'h05);
      step(OP_ADD, 8'h00);
      check_out("add_one", 8'h00, 1'b0);
      check("add_one_empty", {31'd0, bus.empty}, 32'd0);
      step(OP_POP, 8'h00);
      check_out("add_one_pop", 8'h05, 1'b0);
      check("add_one_pop_empty", {31'd0, bus.empty}, 32'd1);

      // Ignored ADD holds a set overflow flag, then reset mid-sequence
      step(OP_PUSH, 8'h7F);
      step(OP_PUSH, 8'h01);
      step(OP_ADD, 8'h00);
      step(OP_ADD, 8'h00);
      check_out("add_ign_hold", 8'h80, 1'b1);
      step(OP_PUSH, 8'h09);
      step(OP_PUSH, 8'h0A);
      reset_with(OP_ADD);
      check_out("rst_mid", 8'h00, 1'b0);
      check("rst_mid_empty", {31'd0, bus.empty}, 32'd1);
      check("rst_mid_full", {31'd0, bus.full}, 32'd0);
      step(OP_POP, 8'h00);
      check_out("rst_mid_pop", 8'h00, 1'b0);
      check("rst_mid_pop_empty", {31'd0, bus.empty}, 32'd1);

      // Final report
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/stack.md
STACK -- requirements
Module: stack

Interface
REQ-001 SHALL have parameter DEPTH, default 256, maximum number of stored entries (power of two, >=2).
REQ-002 SHALL have parameter WIDTH, default 8, data width in bits; data is two's-complement signed.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 opcode  input  3  operation executed on each rising edge.
REQ-007 input_data  input  WIDTH  operand for PUSH.
REQ-008 output_data  output  WIDTH  registered result of the last POP/ADD/MUL.
REQ-009 empty  output  1  high when the entry count is 0.
REQ-010 full  output  1  high when the entry count equals DEPTH.
REQ-011 overflow  output  1  registered signed-overflow flag of the last ADD/MUL.

Function
REQ-012 Opcode encoding SHALL be 000 NOP, 100 ADD, 101 MUL, 110 PUSH, 111 POP; codes 001, 010 and 011 SHALL act as NOP.
REQ-013 One operation SHALL execute per clock with opcode sampled at the rising edge; every result SHALL be visible one cycle after the sampling edge.
REQ-014 PUSH when not full SHALL store input_data on top and increment the count; PUSH when full SHALL be ignored with no state change.
REQ-015 POP when not empty SHALL drive output_data with the top entry and decrement the count; POP when empty SHALL be ignored and hold output_data.
REQ-016 ADD with count >=2 SHALL remove the top two entries, push their WIDTH-bit wrapped sum, drive output_data with it and reduce the count by 1.
REQ-017 For ADD, overflow SHALL be 1 when both operands have equal sign and the sum sign differs.
REQ-018 MUL with count >=2 SHALL behave as ADD using the low WIDTH bits of the signed product.
REQ-019 For MUL, overflow SHALL be 1 when the full 2*WIDTH signed product is outside the signed WIDTH range.
REQ-020 ADD or MUL with count <2 SHALL be ignored with no state change.
REQ-021 overflow SHALL be cleared by every executed PUSH or POP and held by NOP and ignored operations.
REQ-022 empty and full SHALL be combinational decodes of the count register, which is $clog2(DEPTH)+1 bits wide.
REQ-023 output_data SHALL hold between updates.

Reset
REQ-024 On rst, the count SHALL be set to 0 (empty=1, full=0), output_data to 0 and overflow to 0; rst SHALL override any opcode in the same cycle.
REQ-025 Storage contents SHALL not need clearing on reset.

Configuration
REQ-026 Macro STACK_MUL_EN defined SHALL compile in MUL per REQ-018 and REQ-019.
REQ-027 Without STACK_MUL_EN, opcode 101 SHALL act as NOP and no multiplier SHALL be synthesized.

Structure
REQ-028 Package stack_pkg SHALL hold the opcode enum typedef (OP_NOP, OP_ADD, OP_MUL, OP_PUSH, OP_POP) and the opcode width constant.
REQ-029 Arithmetic SHALL be in sub-module stack_alu (inputs a, b and op; outputs result and ovf), combinational, parameterized by WIDTH.
REQ-030 The stack top module SHALL contain the storage array, count register and control.

Verification (DEPTH=256, WIDTH=8, STACK_MUL_EN defined)
REQ-031 Push 1..256 in consecutive cycles, then push 257 -> full=1 after the 256th push; the 257th push is ignored and the count stays 256.
REQ-032 Pop 256 times, then pop once more -> output_data is 256,255,...,1 (8-bit values 0,255,...,1), empty=1 after the last pop, and the extra pop holds output_data=1.
REQ-033 Push 1, push -2, ADD -> output_data=-1, overflow=0; then push -3, push 4, MUL -> output_data=-12, overflow=0.
REQ-034 Push 127, push 1, ADD -> output_data=-128, overflow=1; then push -127, push -2, MUL -> output_data=-2, overflow=1.
REQ-035 ADD on empty stack, ADD with one entry, and rst asserted mid-sequence -> no state change for the ADDs; after rst, empty=1, output_data=0 and overflow=0.
